// File: rtl/vdcm_dec_pkg.sv
// Shared types and helpers for the slice read scheduler.
package vdcm_dec_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        READ     = 2'd1,
        DONE     = 2'd2
    } rd_state_e;

    localparam int PIX_PER_WORD = 4;

    // Number of PIX_PER_WORD-pixel words in one slice line; never less than one.
    function automatic logic [15:0] words_per_slice(input logic [15:0] slice_width);
        logic [15:0] w;
        w = slice_width >> $clog2(PIX_PER_WORD);
        if (w == 16'd0) begin
            w = 16'd1;
        end
        return w;
    endfunction

    // Select width that stays legal even for a single-slice build.
    function automatic int sel_width(input int nbr_slices);
        return (nbr_slices > 1) ? $clog2(nbr_slices) : 1;
    endfunction

endpackage

// File: rtl/slice_rd_scheduler_if.sv
// Read-side bus between the slice sync buffers, the scheduler and the output stage.
// underflow_err exists only when SLICE_RD_SCHED_WDOG_EN is defined.
interface slice_rd_scheduler_if
    import vdcm_dec_pkg::*;
#(
    parameter int MAX_NBR_SLICES = 2
);
    localparam int SEL_W = sel_width(MAX_NBR_SLICES);

    logic [MAX_NBR_SLICES-1:0] buf_empty;
    logic [MAX_NBR_SLICES-1:0] buf_sof;
    logic                      out_ready;
    logic [MAX_NBR_SLICES-1:0] rd_en;
    logic [SEL_W-1:0]          rd_sel;
    logic                      rd_sol;
    logic                      rd_eol;
    logic                      rd_eof;
    logic                      busy;
`ifdef SLICE_RD_SCHED_WDOG_EN
    logic                      underflow_err;
`endif

    // Scheduler side.
    modport master (
        input  buf_empty,
        input  buf_sof,
        input  out_ready,
        output rd_en,
        output rd_sel,
        output rd_sol,
        output rd_eol,
        output rd_eof,
`ifdef SLICE_RD_SCHED_WDOG_EN
        output underflow_err,
`endif
        output busy
    );

    // Buffer / downstream side.
    modport slave (
        output buf_empty,
        output buf_sof,
        output out_ready,
        input  rd_en,
        input  rd_sel,
        input  rd_sol,
        input  rd_eol,
        input  rd_eof,
`ifdef SLICE_RD_SCHED_WDOG_EN
        input  underflow_err,
`endif
        input  busy
    );

endinterface

// File: rtl/slice_rd_scheduler.sv
// Read-side sequencer for the per-slice output sync buffers (output clock domain).
// Walks slices in raster order, one line chunk per slice, and flags sol/eol/eof.
// Optional stall watchdog with sticky underflow_err: define SLICE_RD_SCHED_WDOG_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT_SOF | idle, waiting for buf_sof[0] to start a frame
// READ     | frame in progress, one word per fire, pauses on empty/backpressure
// DONE     | single idle cycle after the last word of the frame
module slice_rd_scheduler
    import vdcm_dec_pkg::*;
#(
    parameter int MAX_NBR_SLICES   = 2,
    parameter int MAX_SLICE_WIDTH  = 2560,
    parameter int MAX_SLICE_HEIGHT = 2560
) (
    input  logic                               clk_out_int,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [9:0]                         slices_per_line,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
    input  logic [15:0]                        frame_height,
    slice_rd_scheduler_if.master               bus
);

    localparam int SEL_W  = sel_width(MAX_NBR_SLICES);
    localparam int WCNT_W = $clog2(MAX_SLICE_WIDTH >> 2) + 1;

    rd_state_e          state_q, state_d;
    logic [SEL_W-1:0]   rd_sel_q, rd_sel_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]        line_cnt_q, line_cnt_d;
    logic [WCNT_W-1:0]  words_q, words_d;
    logic [15:0]        lines_q, lines_d;
    logic [SEL_W-1:0]   sel_last_q, sel_last_d;

    logic [9:0]         spl_clamped;
    logic [WCNT_W-1:0]  words_n;
    logic [15:0]        lines_n;
    logic [SEL_W-1:0]   sel_last_n;

    logic               sof;
    logic               fire;
    logic               take;
    logic               start_frame;
    logic               last_word;
    logic               last_sel;
    logic               last_line;

    // Only slice 0 carries the frame start for the whole line.
    logic               unused_sof;
    assign unused_sof = ^bus.buf_sof;

    // Frame configuration as it would be latched this cycle (degenerate values fixed up).
    always_comb begin
        spl_clamped = slices_per_line;
        if (slices_per_line == 10'd0) begin
            spl_clamped = 10'd1;
        end else if (slices_per_line > 10'(MAX_NBR_SLICES)) begin
            spl_clamped = 10'(MAX_NBR_SLICES);
        end
        sel_last_n = SEL_W'(spl_clamped - 10'd1);
        words_n    = WCNT_W'(words_per_slice(16'(slice_width)));
        lines_n    = (frame_height == 16'd0) ? 16'd1 : frame_height;
    end

    // Handshake qualifiers; sof and flush both suppress the word of their cycle.
    always_comb begin
        sof         = bus.buf_sof[0];
        fire        = bus.out_ready & ~bus.buf_empty[rd_sel_q];
        take        = (state_q == READ) & fire & ~sof & ~flush;
        start_frame = ~flush & sof & ((state_q == WAIT_SOF) | (state_q == READ));
        last_word   = (word_cnt_q == words_q - WCNT_W'(1));
        last_sel    = (rd_sel_q == sel_last_q);
        last_line   = (line_cnt_q == lines_q - 16'd1);
    end

    // Next-state, counter and config-latch logic.
    always_comb begin
        state_d    = state_q;
        rd_sel_d   = rd_sel_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        words_d    = words_q;
        lines_d    = lines_q;
        sel_last_d = sel_last_q;

        if (flush) begin
            state_d    = WAIT_SOF;
            rd_sel_d   = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
        end else if (start_frame) begin
            // Covers both a normal start and an early header while reading.
            state_d    = READ;
            rd_sel_d   = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
            words_d    = words_n;
            lines_d    = lines_n;
            sel_last_d = sel_last_n;
        end else begin
            case (state_q)
                WAIT_SOF: begin
                    state_d = WAIT_SOF;
                end
                READ: begin
                    if (take) begin
                        if (last_word) begin
                            word_cnt_d = '0;
                            if (last_sel) begin
                                rd_sel_d   = '0;
                                line_cnt_d = line_cnt_q + 16'd1;
                                if (last_line) begin
                                    state_d = DONE;
                                end
                            end else begin
                                rd_sel_d = rd_sel_q + SEL_W'(1);
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = WAIT_SOF;
                end
                default: begin
                    state_d = WAIT_SOF;
                end
            endcase
        end
    end

    // State, counter and latched-config registers.
    always_ff @(posedge clk_out_int) begin
        if (!rst_n) begin
            state_q    <= WAIT_SOF;
            rd_sel_q   <= '0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            words_q    <= WCNT_W'(1);
            lines_q    <= 16'd1;
            sel_last_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_sel_q   <= rd_sel_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            words_q    <= words_d;
            lines_q    <= lines_d;
            sel_last_q <= sel_last_d;
        end
    end

    // Strobes and markers decoded straight from registered state and this cycle's handshake.
    always_comb begin
        bus.rd_en = '0;
        for (int i = 0; i < MAX_NBR_SLICES; i++) begin
            bus.rd_en[i] = take && (rd_sel_q == SEL_W'(i));
        end
        bus.rd_sel = rd_sel_q;
        bus.rd_sol = take & (rd_sel_q == '0) & (word_cnt_q == '0);
        bus.rd_eol = take & last_word & last_sel;
        bus.rd_eof = take & last_word & last_sel & last_line;
        bus.busy   = (state_q == READ);
    end

`ifdef SLICE_RD_SCHED_WDOG_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        underflow_q, underflow_d;
    logic        stall;

    // Count consecutive cycles where downstream is ready but the current buffer is dry.
    always_comb begin
        stall       = (state_q == READ) & bus.out_ready & bus.buf_empty[rd_sel_q] & ~sof & ~flush;
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
        end
        underflow_d = underflow_q | (stall_cnt_d == 16'hFFFF);
        if (flush | sof) begin
            underflow_d = 1'b0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_out_int) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.underflow_err = underflow_q;
`endif

    a_rd_en_onehot: assert property (@(posedge clk_out_int) disable iff (!rst_n)
        $onehot0(bus.rd_en));

    a_height_range: assert property (@(posedge clk_out_int) disable iff (!rst_n)
        start_frame |-> (32'(frame_height) <= MAX_SLICE_HEIGHT));

endmodule

// File: tb/tb_slice_rd_scheduler.sv
// Directed vector bench for slice_rd_scheduler.
module tb_slice_rd_scheduler;
    import vdcm_dec_pkg::*;

    logic        clk_out_int = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [9:0]  slices_per_line;
    logic [11:0] slice_width;
    logic [15:0] frame_height;

    always #5 clk_out_int = ~clk_out_int;

    slice_rd_scheduler_if #(.MAX_NBR_SLICES(2)) bus ();

    slice_rd_scheduler #(
        .MAX_NBR_SLICES   (2),
        .MAX_SLICE_WIDTH  (2560),
        .MAX_SLICE_HEIGHT (2560)
    ) dut (
        .clk_out_int     (clk_out_int),
        .rst_n           (rst_n),
        .flush           (flush),
        .slices_per_line (slices_per_line),
        .slice_width     (slice_width),
        .frame_height    (frame_height),
        .bus             (bus.master)
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        sof0;
        logic        ready;
        logic [1:0]  empty;
        logic [9:0]  spl;
        logic [11:0] sw;
        logic [15:0] fh;
        logic [1:0]  en;
        logic        sel;
        logic        sol;
        logic        eol;
        logic        eof;
        logic        busy;
        int          tag;
    } vec_t;

    vec_t        vq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [9:0]  cur_spl;
    logic [11:0] cur_sw;
    logic [15:0] cur_fh;
    int          cur_tag;

    function automatic void add(input logic r, input logic f, input logic s, input logic rdy,
                                input logic [1:0] emp, input logic [1:0] en, input logic sel,
                                input logic sol, input logic eol, input logic eof, input logic bsy);
        vec_t v;
        v.rst_n = r;   v.flush = f;  v.sof0 = s;  v.ready = rdy; v.empty = emp;
        v.spl   = cur_spl; v.sw = cur_sw; v.fh = cur_fh;
        v.en    = en;  v.sel = sel;  v.sol = sol; v.eol = eol;   v.eof = eof;
        v.busy  = bsy; v.tag = cur_tag;
        vq.push_back(v);
    endfunction

    // Idle / DONE cycles: nothing fires, not busy.
    function automatic void idle(input int n);
        for (int i = 0; i < n; i++)
            add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Frame header seen in WAIT_SOF.
    function automatic void sof_wait();
        add(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Strobes k0..k1-1 of the 2-slice x 2-word x 3-line frame; bp inserts a not-ready cycle before each.
    function automatic void strobes(input int k0, input int k1, input bit bp);
        logic sk;
        for (int k = k0; k < k1; k++) begin
            sk = ((k % 4) >= 2);
            if (bp)
                add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, sk, 1'b0, 1'b0, 1'b0, 1'b1);
            add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, sk ? 2'b10 : 2'b01, sk,
                (k % 4) == 0, (k % 4) == 3, k == 11, 1'b1);
        end
    endfunction

    task automatic drive(input vec_t v);
        rst_n           = v.rst_n;
        flush           = v.flush;
        bus.buf_sof     = {1'b0, v.sof0};
        bus.out_ready   = v.ready;
        bus.buf_empty   = v.empty;
        slices_per_line = v.spl;
        slice_width     = v.sw;
        frame_height    = v.fh;
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.buf_sof     = 2'b00;
        bus.buf_empty   = 2'b00;
        bus.out_ready   = 1'b1;
        slices_per_line = 10'd2;
        slice_width     = 12'd8;
        frame_height    = 16'd3;

        cur_spl = 10'd2; cur_sw = 12'd8; cur_fh = 16'd3;

        // 0: reset state, and reset beats a simultaneous sof
        cur_tag = 0;
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // 1: nominal frame; config changed mid-frame must be ignored
        cur_tag = 1;
        sof_wait();
        cur_spl = 10'd1; cur_sw = 12'd40; cur_fh = 16'd9;
        strobes(0, 12, 1'b0);
        idle(2);
        cur_spl = 10'd2; cur_sw = 12'd8; cur_fh = 16'd3;

        // 2: backpressure with out_ready alternating
        cur_tag = 2;
        sof_wait();
        strobes(0, 12, 1'b1);
        idle(2);

        // 3: slice 1 empty for 20 cycles, then resume where it stopped
        cur_tag = 3;
        sof_wait();
        strobes(0, 2, 1'b0);
        for (int i = 0; i < 20; i++)
            add(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        strobes(2, 4, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 4: degenerate config -> 1 slice, 1 word, 1 line
        cur_tag = 4;
        cur_spl = 10'd0; cur_sw = 12'd2; cur_fh = 16'd0;
        sof_wait();
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // 5: slices_per_line above max clamps to 2; width 4 -> 1 word; 1 line
        cur_tag = 5;
        cur_spl = 10'd5; cur_sw = 12'd4; cur_fh = 16'd1;
        sof_wait();
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        cur_spl = 10'd2; cur_sw = 12'd8; cur_fh = 16'd3;

        // 6: early sof after 5 strobes with a ready word pending -> restart, full frame follows
        cur_tag = 6;
        sof_wait();
        strobes(0, 5, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        strobes(0, 12, 1'b0);
        idle(2);

        // 7: flush mid-frame, restart, flush again, flush beats sof in WAIT_SOF
        cur_tag = 7;
        sof_wait();
        strobes(0, 3, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        sof_wait();
        strobes(0, 1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 8: reset mid-frame
        cur_tag = 8;
        sof_wait();
        strobes(0, 3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        foreach (vq[i]) begin
            @(negedge clk_out_int);
            drive(vq[i]);
            #1;
            checks++;
            if ({bus.rd_en, bus.rd_sel, bus.rd_sol, bus.rd_eol, bus.rd_eof, bus.busy} !==
                {vq[i].en, vq[i].sel, vq[i].sol, vq[i].eol, vq[i].eof, vq[i].busy}) begin
                failures++;
                $display("FAIL vec%0d tag=%0d (got/exp) rd_en=%b/%b rd_sel=%0d/%0d sol=%b/%b eol=%b/%b eof=%b/%b busy=%b/%b",
                         i, vq[i].tag, bus.rd_en, vq[i].en, bus.rd_sel, vq[i].sel,
                         bus.rd_sol, vq[i].sol, bus.rd_eol, vq[i].eol,
                         bus.rd_eof, vq[i].eof, bus.busy, vq[i].busy);
            end
        end

`ifdef SLICE_RD_SCHED_WDOG_EN
        // Watchdog: 65534 stall cycles stay clean, the 65535th sets the sticky flag.
        @(negedge clk_out_int);
        rst_n = 1'b1; flush = 1'b0; bus.buf_empty = 2'b00; bus.out_ready = 1'b1;
        slices_per_line = 10'd2; slice_width = 12'd8; frame_height = 16'd3;
        bus.buf_sof = 2'b01;
        @(negedge clk_out_int);
        bus.buf_sof   = 2'b00;
        bus.buf_empty = 2'b01;
        repeat (65534) @(negedge clk_out_int);
        #1;
        checks++;
        if (bus.underflow_err !== 1'b0 || bus.rd_en !== 2'b00 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wdog_before (got/exp) underflow_err=%b/0 rd_en=%b/00 busy=%b/1",
                     bus.underflow_err, bus.rd_en, bus.busy);
        end
        @(negedge clk_out_int);
        #1;
        checks++;
        if (bus.underflow_err !== 1'b1) begin
            failures++;
            $display("FAIL wdog_set (got/exp) underflow_err=%b/1", bus.underflow_err);
        end
        repeat (3) @(negedge clk_out_int);
        #1;
        checks++;
        if (bus.underflow_err !== 1'b1) begin
            failures++;
            $display("FAIL wdog_sticky (got/exp) underflow_err=%b/1", bus.underflow_err);
        end
        @(negedge clk_out_int);
        bus.buf_sof = 2'b01;
        @(negedge clk_out_int);
        bus.buf_sof = 2'b00;
        #1;
        checks++;
        if (bus.underflow_err !== 1'b0) begin
            failures++;
            $display("FAIL wdog_clear (got/exp) underflow_err=%b/0", bus.underflow_err);
        end
        flush = 1'b1;
        @(negedge clk_out_int);
        flush = 1'b0;
        bus.buf_empty = 2'b00;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slice_rd_scheduler.md
Name: slice_rd_scheduler

Overview:
- Read-side sequencer for the per-slice output sync buffers, running in the output clock domain.
- Walks the slices in raster order: one line chunk of (slice_width>>2) 4-pixel words from slice 0, then slice 1, up to slices_per_line-1, then the next line.
- Drives per-slice read enables and the mux select, and flags start-of-line, end-of-line and end-of-frame.
- Pauses on buffer empty and on downstream backpressure.

Parameters:
- MAX_NBR_SLICES, 2, number of slice buffers and width of the per-slice vectors.
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels; sets the word-counter width to $clog2(MAX_SLICE_WIDTH>>2)+1.
- MAX_SLICE_HEIGHT, 2560, maximum slice height; informational only, used for assertions.

Ports:
- clk_out_int  in  1  output-domain clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous abort; returns the block to WAIT_SOF.
- slices_per_line  in  10  number of active slices.
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels.
- frame_height  in  16  lines per frame.
- buf_empty  in  MAX_NBR_SLICES  per-slice buffer empty.
- buf_sof  in  MAX_NBR_SLICES  per-slice start-of-frame marker, read side.
- out_ready  in  1  downstream can accept a word this cycle.
- rd_en  out  MAX_NBR_SLICES  per-slice read strobe.
- rd_sel  out  $clog2(MAX_NBR_SLICES)  slice currently being read.
- rd_sol  out  1  qualifies the first word of a line.
- rd_eol  out  1  qualifies the last word of a line (last slice).
- rd_eof  out  1  qualifies the last word of the frame.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to WAIT_SOF.
  - rd_sel, word_cnt, line_cnt and busy go to 0.
  - rd_en, rd_sol, rd_eol and rd_eof are 0, since they are decoded from the reset state.
  - Reset mid-frame abandons the frame and issues no further reads.
- Configuration is latched on entry to READ:
  - slices_per_line==0 is treated as 1; values above MAX_NBR_SLICES clamp to MAX_NBR_SLICES.
  - words = max(slice_width>>2, 1).
  - lines = max(frame_height, 1).
- States:
  - WAIT_SOF: wait for buf_sof[0]=1, then latch config, clear counters and go to READ.
  - READ: a word is taken on cycles where fire = out_ready & ~buf_empty[rd_sel]. On each fire:
    - word_cnt increments.
    - At word_cnt==words-1, word_cnt clears and rd_sel advances; rd_sel wraps to 0 after slice slices_per_line-1.
    - On that wrap, line_cnt increments. If line_cnt==lines-1, go to DONE.
  - DONE: one cycle with busy=0, then WAIT_SOF.
- rd_en[s] = (state==READ) & (rd_sel==s) & fire. This is combinational from registered state, so there is zero-cycle latency from ready/empty to the strobe. At most one bit is set per cycle.
- rd_sol = fire & rd_sel==0 & word_cnt==0.
- rd_eol = fire & word_cnt==words-1 & rd_sel==slices_per_line-1.
- rd_eof = rd_eol & line_cnt==lines-1.
- busy = state==READ.
- When buf_empty or ~out_ready holds, the counters and rd_sel hold and no strobe is issued; any stall length is allowed.
- buf_sof[0] while in READ means a new frame header arrived early. The block restarts: config is re-latched, counters clear, it stays in READ, and no read fires that cycle.
- flush has priority over all events except reset. It takes effect in one cycle and returns the block to WAIT_SOF.
- Simultaneous fire and buf_sof[0]: sof wins and the word is not consumed.
- Counter widths are as declared. All compares use the latched values; mid-frame config changes are ignored.

Optional Feature:
- Macro SLICE_RD_SCHED_WDOG_EN, which adds an output port underflow_err (1 bit).
- When defined:
  - A 16-bit stall counter counts consecutive READ cycles with out_ready=1 and buf_empty[rd_sel]=1. It clears on fire.
  - When the counter reaches 0xFFFF, underflow_err sets and stays sticky until reset, flush or the next buf_sof[0].
- When not defined: the port is absent, there is no counter, and behaviour is otherwise identical.

Decomposition:
- Shared package vdcm_dec_pkg holds:
  - the state enum (WAIT_SOF, READ, DONE),
  - PIX_PER_WORD=4,
  - the function words_per_slice(slice_width), which returns max(w>>2,1).
- No sub-module is needed; the watchdog stays inline under the macro.

Test Plan:
- Nominal frame, all stall-free: slice_width=8, slices_per_line=2, frame_height=3, out_ready=1, buffers never empty, pulse buf_sof[0] → 12 strobes in the order rd_en = 01,01,10,10 repeated 3 times. rd_sol on strobes 1, 5 and 9; rd_eol on strobes 4, 8 and 12; rd_eof only on strobe 12; busy drops the cycle after.
- Backpressure: same config with out_ready toggling 1,0 → still 12 strobes, none on out_ready=0 cycles, order unchanged.
- Empty stall: hold buf_empty[1]=1 for 20 cycles while rd_sel=1 → no strobes, counters hold, then resume with a word on slice 1.
- Degenerate config: slices_per_line=0, slice_width=2, frame_height=0 → treated as 1 slice, 1 word, 1 line. A single strobe with rd_sol=rd_eol=rd_eof=1.
- Abort cases:
  - Early sof after 5 strobes → the next strobe carries rd_sol, and a full 12 strobes follow.
  - flush mid-frame → busy=0 the next cycle, no strobes until buf_sof[0].
  - rst_n=0 mid-frame → all outputs 0 on the next edge.
- With SLICE_RD_SCHED_WDOG_EN: hold buf_empty[0]=1 with out_ready=1 for 65535 cycles → underflow_err=1, and it clears on buf_sof[0].
